// File: rtl/core_pkg.sv
// Shared core types: data width, register address type, x0 constant and base opcodes.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/busy_scoreboard.sv
// Per-register busy bits (issue sets, commit clears, flush wipes) and the decode stall for RAW/WAW.
// Hazard is combinational; REGFILE_BYPASS_EN lets a same-cycle commit release the stall early.
module busy_scoreboard
  import core_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  reg_addr_t        issue_rd,
  input  logic             flush,
  input  logic             write_enable,
  input  reg_addr_t        write_reg,
  input  reg_addr_t        rs1_addr,
  input  reg_addr_t        rs2_addr,
  output logic             hazard,
  output logic [NREGS-1:0] busy_vec
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] commit_mask;
  logic [NREGS-1:0] visible;

  always_comb begin
    commit_mask = '0;
    if (write_enable && write_reg != ZERO_REG) commit_mask[write_reg] = 1'b1;

`ifdef REGFILE_BYPASS_EN
    visible = busy_q & ~commit_mask;
`else
    visible = busy_q;
`endif
    visible[0] = 1'b0;

    hazard = issue_valid & (visible[rs1_addr] | visible[rs2_addr] | visible[issue_rd]);

    // Commit clears first so a same-cycle issue to that register leaves it busy.
    busy_d = busy_q & ~commit_mask;
    if (flush) begin
      busy_d = '0;
    end else if (issue_valid && issue_rd != ZERO_REG && !hazard) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/register_file_scoreboard.sv
// Integer register file with write-back commit port, two combinational read ports and busy scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle commit to the read ports and hazard.
module register_file_scoreboard
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  reg_addr_t        rs1_addr,
  input  reg_addr_t        rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  input  logic             issue_valid,
  input  reg_addr_t        issue_rd,
  input  logic             flush,
  input  logic             write_enable,
  input  reg_addr_t        write_reg,
  input  logic [XLEN-1:0]  write_data,
  output logic             hazard,
  output logic [NREGS-1:0] busy_vec,
  output logic [31:0]      commit_count
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [31:0]     commit_count_q, commit_count_d;
  logic            commit;

  assign commit = write_enable && (write_reg != ZERO_REG);

  always_comb begin
    regs_d         = regs_q;
    commit_count_d = commit_count_q;
    if (commit) begin
      regs_d[write_reg] = write_data;
      commit_count_d    = commit_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      commit_count_q <= '0;
    end else begin
      regs_q         <= regs_d;
      commit_count_q <= commit_count_d;
    end
  end

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != ZERO_REG) rs1_data = regs_q[rs1_addr];
    if (rs2_addr != ZERO_REG) rs2_data = regs_q[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (commit && write_reg == rs1_addr) rs1_data = write_data;
    if (commit && write_reg == rs2_addr) rs2_data = write_data;
`endif
  end

  assign commit_count = commit_count_q;

  busy_scoreboard #(
    .NREGS(NREGS)
  ) u_busy (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .flush        (flush),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .hazard       (hazard),
    .busy_vec     (busy_vec)
  );

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: directed table, hand sequences, random traffic vs a reference model.
module tb_register_file_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, write_reg;
  logic [31:0] rs1_data, rs2_data, write_data;
  logic        issue_valid, flush, write_enable, hazard;
  logic [31:0] busy_vec, commit_count;

  register_file_scoreboard dut (
    .clk(clk), .reset(reset),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
    .hazard(hazard), .busy_vec(busy_vec), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state as plain arrays.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [31:0] m_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          iv;
    logic [4:0]  rd, rs1, rs2;
    bit          fl, we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] exp_rs1;
    bit          exp_hz;
    logic [4:0]  bidx;
    bit          bexp;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(bit iv, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              bit fl, bit we, logic [4:0] wr, logic [31:0] wd,
                              logic [31:0] er, bit eh, logic [4:0] bi, bit be);
    vec_t v;
    v.iv = iv; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.fl = fl; v.we = we;
    v.wr = wr; v.wd = wd; v.exp_rs1 = er; v.exp_hz = eh; v.bidx = bi; v.bexp = be;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = '0;
  endfunction

  function automatic bit m_committing(input logic [4:0] a);
    return write_enable && write_reg == a && a != 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (BYP && m_committing(a)) return write_data;
    return m_regs[a];
  endfunction

  function automatic bit m_stalls_on(input logic [4:0] a);
    return a != 0 && m_busy[a] && !(BYP && m_committing(a));
  endfunction

  function automatic bit m_hazard();
    return issue_valid && (m_stalls_on(rs1_addr) || m_stalls_on(rs2_addr) || m_stalls_on(issue_rd));
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic drive(input vec_t v);
    issue_valid  = v.iv;  issue_rd  = v.rd;
    rs1_addr     = v.rs1; rs2_addr  = v.rs2;
    flush        = v.fl;
    write_enable = v.we;  write_reg = v.wr; write_data = v.wd;
  endtask

  // Called shortly before a rising edge: compare against the model, then let the edge happen.
  task automatic settle_and_clock();
    bit hz;
    chk("rs1_data",     rs1_data,     m_read(rs1_addr));
    chk("rs2_data",     rs2_data,     m_read(rs2_addr));
    chk("hazard",       {31'd0, hazard}, {31'd0, m_hazard()});
    chk("busy_vec",     busy_vec,     m_busy_vec());
    chk("commit_count", commit_count, m_cnt);
    hz = m_hazard();
    @(posedge clk);
    if (write_enable && write_reg != 0) begin
      m_regs[write_reg] = write_data;
      m_busy[write_reg] = 1'b0;
      m_cnt             = m_cnt + 32'd1;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else if (issue_valid && issue_rd != 0 && !hz) begin
      m_busy[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = mk(0,  0, 5, 0, 0, 0, 0, 32'h0,        32'h0, 0, 0, 0);
    tbl[1]  = mk(1,  3, 0, 0, 0, 0, 0, 32'h0,        32'h0, 0, 0, 0);
    tbl[2]  = mk(1, 10, 3, 0, 0, 0, 0, 32'h0,        32'h0, 1, 3, 1);
    tbl[3]  = mk(1, 10, 3, 0, 0, 1, 3, 32'hDEADBEEF, BYP ? 32'hDEADBEEF : 32'h0, !BYP, 3, 1);
    tbl[4]  = mk(1, 11, 3, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 3, 0);
    tbl[5]  = mk(0,  0, 0, 0, 0, 1, 0, 32'h1234,     32'h0, 0, 0, 0);
    tbl[6]  = mk(1,  7, 7, 0, 0, 1, 7, 32'h55,       BYP ? 32'h55 : 32'h0, 0, 7, 0);
    tbl[7]  = mk(0,  0, 7, 0, 0, 0, 0, 32'h0,        32'h55, 0, 7, 1);
    tbl[8]  = mk(1,  2, 0, 0, 0, 0, 0, 32'h0,        32'h0, 0, 0, 0);
    tbl[9]  = mk(1,  9, 0, 0, 0, 0, 0, 32'h0,        32'h0, 0, 2, 1);
    tbl[10] = mk(1, 12, 4, 0, 1, 1, 4, 32'hA,        BYP ? 32'hA : 32'h0, 0, 9, 1);
    tbl[11] = mk(1,  2, 4, 9, 0, 0, 0, 32'h0,        32'hA, 0, 9, 0);

    // Reset state
    reset = 1'b0;
    drive(idle);
    rs1_addr = 5'd5;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_rs1_x5",   rs1_data,     32'h0);
    chk("reset_busy",     busy_vec,     32'h0);
    chk("reset_count",    commit_count, 32'h0);
    chk("reset_hazard",   {31'd0, hazard}, 32'h0);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i]);
      #4;
      chk($sformatf("tbl%0d_rs1", i), rs1_data, tbl[i].exp_rs1);
      chk($sformatf("tbl%0d_hz", i), {31'd0, hazard}, {31'd0, tbl[i].exp_hz});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy_vec[tbl[i].bidx]}, {31'd0, tbl[i].bexp});
      settle_and_clock();
    end
    chk("after_flush_busy", busy_vec, 32'h0000_0004);

    // Counter wrap from a preloaded all-ones state
    force dut.commit_count_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.commit_count_q;
    drive(mk(0, 0, 0, 0, 0, 1, 1, 32'h77, 0, 0, 0, 0));
    #3;
    chk("cnt_preload", commit_count, 32'hFFFF_FFFF);
    settle_and_clock();
    drive(idle);
    #1;
    chk("cnt_wrap", commit_count, 32'h0);

    // Reset asserted in the middle of a stall
    drive(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #3;
    settle_and_clock();
    drive(mk(1, 6, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    chk("stall_hz", {31'd0, hazard}, 32'h1);
    reset = 1'b0;
    #1;
    chk("rst_mid_hz",    {31'd0, hazard}, 32'h0);
    chk("rst_mid_busy",  busy_vec, 32'h0);
    chk("rst_mid_count", commit_count, 32'h0);
    m_reset();
    @(negedge clk);
    drive(idle);
    reset = 1'b1;
    @(negedge clk);

    // Random traffic against the model; small address range keeps hazards frequent
    for (int n = 0; n < 400; n++) begin
      issue_valid  = $urandom_range(0, 1) == 1;
      issue_rd     = 5'($urandom_range(0, 7));
      rs1_addr     = 5'($urandom_range(0, 7));
      rs2_addr     = 5'($urandom_range(0, 7));
      flush        = $urandom_range(0, 15) == 0;
      write_enable = $urandom_range(0, 1) == 1;
      write_reg    = 5'($urandom_range(0, 7));
      write_data   = $urandom;
      #4;
      settle_and_clock();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
